// File: rtl/pin_entry_pkg.sv
// Shared types and constants for the keypad PIN entry front-end.
package pin_entry_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } pin_state_t;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned CODE_W     = 16;
    localparam int unsigned MAX_DIGIT  = 9;

endpackage

// File: rtl/pin_entry_timer.sv
// Inactivity down-counter: expires after TIMEOUT_CYCLES running cycles with no restart.
module pin_entry_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic expired
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tcnt;

    always_ff @(posedge clk) begin
        if (rst || restart || !run) begin
            tcnt <= LOAD;
        end else if (tcnt != '0) begin
            tcnt <= tcnt - 1'b1;
        end
    end

    assign expired = run && (tcnt == '0);

endmodule

// File: rtl/pin_entry_collector.sv
// Collects four BCD key digits MSB-first and submits them as a 16-bit code.
// Optional inactivity timeout is built when PIN_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | no vehicle at the gate, keys ignored
// COLLECT | 0..3 digits buffered
// FULL    | 4 digits buffered, waiting for enter
module pin_entry_collector
    import pin_entry_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vehicle_arrival,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        key_enter,
    input  logic        key_clear,
    output logic [15:0] code,
    output logic        code_ack,
    output logic [2:0]  digits_entered,
    output logic        entry_err,
    output logic        entry_timeout
);

    pin_state_t          state, state_n;
    logic [CODE_W-1:0]   sr, sr_n;
    logic [2:0]          cnt, cnt_n;
    logic [CODE_W-1:0]   code_n;
    logic                ack_n, err_n, to_n;
    logic                key_act;
    logic                timer_run;
    logic                timer_expired;

    assign timer_run = vehicle_arrival && (state != IDLE) && (cnt != 3'd0);

`ifdef PIN_TIMEOUT_EN
    pin_entry_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (timer_run),
        .restart(key_act),
        .expired(timer_expired)
    );
`else
    // Legal range starts at 2, so this is constantly low.
    assign timer_expired = (TIMEOUT_CYCLES == 0) && timer_run;
`endif

    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        code_n  = code;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        to_n    = 1'b0;
        key_act = 1'b0;
        if (!vehicle_arrival) begin
            state_n = IDLE;
            sr_n    = '0;
            cnt_n   = 3'd0;
            code_n  = '0;
        end else begin
            case (state)
                IDLE: state_n = COLLECT;
                COLLECT, FULL: begin
                    if (key_clear) begin
                        key_act = 1'b1;
                        sr_n    = '0;
                        cnt_n   = 3'd0;
                        state_n = COLLECT;
                    end else if (key_enter) begin
                        key_act = 1'b1;
                        if (state == FULL) begin
                            code_n  = sr;
                            ack_n   = 1'b1;
                            sr_n    = '0;
                            cnt_n   = 3'd0;
                            state_n = COLLECT;
                        end else begin
                            err_n = 1'b1;
                        end
                    end else if (digit_valid) begin
                        if (state == FULL || digit > 4'(MAX_DIGIT)) begin
                            err_n = 1'b1;
                        end else begin
                            key_act = 1'b1;
                            sr_n    = {sr[CODE_W-DIGIT_W-1:0], digit};
                            cnt_n   = cnt + 3'd1;
                            if (cnt == 3'(NUM_DIGITS - 1)) state_n = FULL;
                        end
                    end else if (timer_expired) begin
                        sr_n    = '0;
                        cnt_n   = 3'd0;
                        state_n = COLLECT;
                        to_n    = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sr            <= '0;
            cnt           <= 3'd0;
            code          <= '0;
            code_ack      <= 1'b0;
            entry_err     <= 1'b0;
            entry_timeout <= 1'b0;
        end else begin
            state         <= state_n;
            sr            <= sr_n;
            cnt           <= cnt_n;
            code          <= code_n;
            code_ack      <= ack_n;
            entry_err     <= err_n;
            entry_timeout <= to_n;
        end
    end

    assign digits_entered = cnt;

endmodule

// File: tb/tb_pin_entry_collector.sv
// Directed self-checking bench for pin_entry_collector (timeout expectations follow PIN_TIMEOUT_EN).
module tb_pin_entry_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        vehicle_arrival;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        key_enter;
    logic        key_clear;
    logic [15:0] code;
    logic        code_ack;
    logic [2:0]  digits_entered;
    logic        entry_err;
    logic        entry_timeout;

    int checks = 0;
    int errors = 0;

    pin_entry_collector #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .vehicle_arrival(vehicle_arrival),
        .digit_valid    (digit_valid),
        .digit          (digit),
        .key_enter      (key_enter),
        .key_clear      (key_clear),
        .code           (code),
        .code_ack       (code_ack),
        .digits_entered (digits_entered),
        .entry_err      (entry_err),
        .entry_timeout  (entry_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press_digit(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        tick();
        digit_valid = 1'b0;
    endtask

    task automatic press_enter();
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
    endtask

    task automatic press_clear();
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_code"}, 32'(code), 32'h0);
        chk({tag, "_ack"}, 32'(code_ack), 32'h0);
        chk({tag, "_digits"}, 32'(digits_entered), 32'h0);
        chk({tag, "_err"}, 32'(entry_err), 32'h0);
        chk({tag, "_timeout"}, 32'(entry_timeout), 32'h0);
    endtask

    initial begin
        rst = 1'b1; vehicle_arrival = 1'b0; digit_valid = 1'b0;
        digit = 4'h0; key_enter = 1'b0; key_clear = 1'b0;
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;

        // IDLE ignores keys and raises no error
        press_digit(4'd5);
        chk("idle_digits", 32'(digits_entered), 32'd0);
        chk("idle_err", 32'(entry_err), 32'd0);

        vehicle_arrival = 1'b1;
        tick();

        // basic submit 5,9,9,0
        press_digit(4'd5); chk("basic_cnt1", 32'(digits_entered), 32'd1);
        press_digit(4'd9); chk("basic_cnt2", 32'(digits_entered), 32'd2);
        press_digit(4'd9); chk("basic_cnt3", 32'(digits_entered), 32'd3);
        press_digit(4'd0); chk("basic_cnt4", 32'(digits_entered), 32'd4);
        chk("basic_no_ack_early", 32'(code_ack), 32'd0);
        press_enter();
        chk("basic_code", 32'(code), 32'h5990);
        chk("basic_ack", 32'(code_ack), 32'd1);
        chk("basic_cnt0", 32'(digits_entered), 32'd0);
        tick();
        chk("basic_ack_drop", 32'(code_ack), 32'd0);
        chk("basic_code_hold", 32'(code), 32'h5990);

        // illegal digit
        press_digit(4'hB);
        chk("illegal_digit_err", 32'(entry_err), 32'd1);
        chk("illegal_digit_cnt", 32'(digits_entered), 32'd0);
        tick();
        chk("illegal_err_drop", 32'(entry_err), 32'd0);

        // early enter after 2 digits
        press_digit(4'd1);
        press_digit(4'd2);
        press_enter();
        chk("early_enter_err", 32'(entry_err), 32'd1);
        chk("early_enter_ack", 32'(code_ack), 32'd0);
        chk("early_enter_cnt", 32'(digits_entered), 32'd2);
        chk("early_enter_code", 32'(code), 32'h5990);

        // clear, then priority: clear and digit together with 3 buffered
        press_clear();
        chk("clear_cnt", 32'(digits_entered), 32'd0);
        chk("clear_code_kept", 32'(code), 32'h5990);
        press_digit(4'd1); press_digit(4'd2); press_digit(4'd3);
        chk("pre_clr_cnt", 32'(digits_entered), 32'd3);
        key_clear = 1'b1; digit_valid = 1'b1; digit = 4'd4;
        tick();
        key_clear = 1'b0; digit_valid = 1'b0;
        chk("prio_clear_cnt", 32'(digits_entered), 32'd0);
        chk("prio_clear_err", 32'(entry_err), 32'd0);

        // retry 1,2,3,4
        press_digit(4'd1); press_digit(4'd2); press_digit(4'd3); press_digit(4'd4);
        press_enter();
        chk("retry_code", 32'(code), 32'h1234);
        chk("retry_ack", 32'(code_ack), 32'd1);

        // second submit 0,0,0,7 with a rejected fifth digit in FULL
        press_digit(4'd0); press_digit(4'd0); press_digit(4'd0); press_digit(4'd7);
        press_digit(4'd5);
        chk("full_digit_err", 32'(entry_err), 32'd1);
        chk("full_digit_cnt", 32'(digits_entered), 32'd4);
        press_enter();
        chk("second_code", 32'(code), 32'h0007);
        chk("second_ack", 32'(code_ack), 32'd1);

        // vehicle leaves with enter pending in FULL
        press_digit(4'd1); press_digit(4'd1); press_digit(4'd1); press_digit(4'd1);
        vehicle_arrival = 1'b0; key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        chk("va_fall_ack", 32'(code_ack), 32'd0);
        chk("va_fall_code", 32'(code), 32'h0);
        chk("va_fall_cnt", 32'(digits_entered), 32'd0);
        // back in IDLE: first cycle with vehicle present still ignores keys
        vehicle_arrival = 1'b1; digit_valid = 1'b1; digit = 4'd3;
        tick();
        digit_valid = 1'b0;
        chk("idle_again_cnt", 32'(digits_entered), 32'd0);
        chk("idle_again_err", 32'(entry_err), 32'd0);
        press_digit(4'd3);
        chk("collect_again_cnt", 32'(digits_entered), 32'd1);
        press_clear();

        // reset mid-entry, then enter
        press_digit(4'd8); press_digit(4'd7); press_digit(4'd6); press_digit(4'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("rst_mid");
        press_enter();
        chk_reset_vals("rst_then_enter");

        // inactivity
        press_digit(4'd2);
        chk("to_cnt1", 32'(digits_entered), 32'd1);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("to_quiet", 32'(entry_timeout), 32'd0);
        end
        tick();
`ifdef PIN_TIMEOUT_EN
        chk("to_pulse", 32'(entry_timeout), 32'd1);
        chk("to_cnt", 32'(digits_entered), 32'd0);
`else
        chk("to_pulse", 32'(entry_timeout), 32'd0);
        chk("to_cnt", 32'(digits_entered), 32'd1);
`endif
        tick();
        chk("to_pulse_drop", 32'(entry_timeout), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
